// File: rtl/uart_lock_sequencer.sv
// uart_lock_sequencer: command/PIN sequencer between the UART receive byte stream and the
// lock actuator. "A" followed by four digits opens the lock if the digits match PIN, and
// "C" closes it. The lock relocks by itself after OPEN_CYCLES. MAX_FAILS consecutive wrong
// attempts put the block into a timed lockout.
// Optional: define UART_LOCK_SEQ_ACK_TX_EN to add a one-byte event acknowledge towards a
// UART transmitter (tx_start / tx_byte / tx_busy).
module uart_lock_sequencer #(
    parameter int unsigned OPEN_CYCLES         = 250000000,
    parameter int unsigned LOCKOUT_CYCLES      = 1500000000,
    parameter int unsigned BYTE_TIMEOUT_CYCLES = 50000000,
    parameter logic [15:0] PIN                 = 16'h1234,
    parameter int unsigned MAX_FAILS           = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_byte,
    output logic       lock_open,
    output logic       locked_out,
    output logic [3:0] fail_cnt,
    output logic       busy
`ifdef UART_LOCK_SEQ_ACK_TX_EN
    ,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    input  logic       tx_busy
`endif
);

    // The timer counts down to zero, so each load is one less than the wanted duration.
    localparam logic [31:0] OpenLoad  = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LockLoad  = 32'(LOCKOUT_CYCLES - 1);
    localparam logic [31:0] ByteLoad  = 32'(BYTE_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  MaxFails  = 4'(MAX_FAILS);

    localparam logic [7:0] ChA = 8'h41;
    localparam logic [7:0] ChC = 8'h43;

    typedef enum logic [1:0] {StIdle, StCollect, StOpen, StLockout} state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] pin_buf_q, pin_buf_d;
    logic [3:0]  fail_cnt_q, fail_cnt_d;
    logic        lock_open_q, lock_open_d;
    logic        locked_out_q, locked_out_d;
    logic        busy_q, busy_d;

    logic        is_digit;
    logic [15:0] pin_next;
    logic [3:0]  fail_inc;
    logic        pin_ok;
    logic        wrong_attempt;

    assign is_digit = (cmd_byte >= 8'h30) && (cmd_byte <= 8'h39);
    assign pin_next = {pin_buf_q[11:0], cmd_byte[3:0]};
    assign fail_inc = (fail_cnt_q >= MaxFails) ? MaxFails : fail_cnt_q + 4'd1;

    // Next-state, shared timer, PIN buffer and fail counter.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        idx_d         = idx_q;
        pin_buf_d     = pin_buf_q;
        fail_cnt_d    = fail_cnt_q;
        pin_ok        = 1'b0;
        wrong_attempt = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_byte == ChA) begin
                    state_d   = StCollect;
                    timer_d   = ByteLoad;
                    idx_d     = 2'd0;
                    pin_buf_d = 16'h0000;
                end
            end
            StCollect: begin
                if (cmd_valid) begin
                    if (is_digit) begin
                        pin_buf_d = pin_next;
                        idx_d     = idx_q + 2'd1;
                        timer_d   = ByteLoad;
                        if (idx_q == 2'd3) begin
                            if (pin_next == PIN) begin
                                pin_ok  = 1'b1;
                                state_d = StOpen;
                                timer_d = OpenLoad;
                            end else begin
                                wrong_attempt = 1'b1;
                            end
                        end
                    end else if (cmd_byte == ChC) begin
                        state_d = StIdle;
                        timer_d = 32'd0;
                    end else if (cmd_byte == ChA) begin
                        idx_d   = 2'd0;
                        timer_d = ByteLoad;
                    end else begin
                        wrong_attempt = 1'b1;
                    end
                end else if (timer_q == 32'd0) begin
                    // Inter-byte timeout: silent abort, partial PIN dropped.
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StOpen: begin
                // A close byte and expiry on the same cycle collapse into one close.
                if ((cmd_valid && cmd_byte == ChC) || timer_q == 32'd0) begin
                    state_d = StIdle;
                    timer_d = 32'd0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            StLockout: begin
                if (timer_q == 32'd0) begin
                    state_d    = StIdle;
                    fail_cnt_d = 4'd0;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = 32'd0;
            end
        endcase

        if (pin_ok) begin
            fail_cnt_d = 4'd0;
        end
        if (wrong_attempt) begin
            fail_cnt_d = fail_inc;
            if (fail_inc == MaxFails) begin
                state_d = StLockout;
                timer_d = LockLoad;
            end else begin
                state_d = StIdle;
                timer_d = 32'd0;
            end
        end

        lock_open_d  = (state_d == StOpen);
        locked_out_d = (state_d == StLockout);
        busy_d       = (state_d == StCollect);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= 32'd0;
            idx_q        <= 2'd0;
            pin_buf_q    <= 16'h0000;
            fail_cnt_q   <= 4'd0;
            lock_open_q  <= 1'b0;
            locked_out_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            pin_buf_q    <= pin_buf_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_open_q  <= lock_open_d;
            locked_out_q <= locked_out_d;
            busy_q       <= busy_d;
        end
    end

    assign lock_open  = lock_open_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_cnt_q;
    assign busy       = busy_q;

`ifdef UART_LOCK_SEQ_ACK_TX_EN
    logic       ev_valid;
    logic [7:0] ev_byte;
    logic       pend_q, pend_d;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] tx_byte_q, tx_byte_d;

    // Event selection and the single-entry pending slot; newest event wins.
    always_comb begin
        ev_valid = 1'b0;
        ev_byte  = 8'h00;
        if (pin_ok) begin
            ev_valid = 1'b1;
            ev_byte  = 8'h4B;
        end else if (wrong_attempt) begin
            ev_valid = 1'b1;
            ev_byte  = (state_d == StLockout) ? 8'h4C : 8'h4E;
        end else if (state_q == StOpen && state_d == StIdle) begin
            ev_valid = 1'b1;
            ev_byte  = 8'h58;
        end

        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        tx_start_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        if (pend_q && !tx_busy) begin
            tx_start_d = 1'b1;
            tx_byte_d  = pend_byte_q;
            pend_d     = 1'b0;
        end
        if (ev_valid) begin
            pend_d      = 1'b1;
            pend_byte_d = ev_byte;
        end
    end

    // Acknowledge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= 8'h00;
        end else begin
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;
`endif

endmodule

// File: tb/tb_uart_lock_sequencer.sv
// Testbench for uart_lock_sequencer: directed scenarios plus random byte traffic, checked
// every cycle against a deadline-based reference model through an expectation queue.
module tb_uart_lock_sequencer;

    localparam int unsigned OPEN_N = 100;
    localparam int unsigned LOCK_N = 200;
    localparam int unsigned BT_N   = 50;
    localparam int unsigned MAXF   = 3;
    localparam logic [15:0] PIN    = 16'h1234;

    typedef struct packed {
        logic       lock_open;
        logic       locked_out;
        logic [3:0] fail_cnt;
        logic       busy;
        logic       tx_start;
        logic [7:0] tx_byte;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       lock_open;
    logic       locked_out;
    logic [3:0] fail_cnt;
    logic       busy;
    logic       tx_busy;
`ifdef UART_LOCK_SEQ_ACK_TX_EN
    logic       tx_start;
    logic [7:0] tx_byte;
`endif

    uart_lock_sequencer #(
        .OPEN_CYCLES        (OPEN_N),
        .LOCKOUT_CYCLES     (LOCK_N),
        .BYTE_TIMEOUT_CYCLES(BT_N),
        .PIN                (PIN),
        .MAX_FAILS          (MAXF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_byte  (cmd_byte),
        .lock_open (lock_open),
        .locked_out(locked_out),
        .fail_cnt  (fail_cnt),
        .busy      (busy)
`ifdef UART_LOCK_SEQ_ACK_TX_EN
        ,
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_busy   (tx_busy)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    obs_t exp_q[$];
    int   cyc_q[$];

    // Reference model: mode plus absolute-cycle deadlines and a list of entered digits.
    localparam int M_IDLE = 0, M_COLLECT = 1, M_OPEN = 2, M_LOCK = 3;
    int       cyc = 0;
    int       m_mode = M_IDLE;
    int       m_deadline = 0;
    int       m_fails = 0;
    int       m_digits[$];
    bit       m_pend = 0;
    int       m_pend_byte = 0;
    bit       m_tx_start = 0;
    int       m_tx_byte = 0;
    int       pin_dec;

    initial pin_dec = int'(PIN[15:12]) * 1000 + int'(PIN[11:8]) * 100 +
                      int'(PIN[7:4]) * 10 + int'(PIN[3:0]);

    function automatic obs_t sample_obs();
        obs_t o;
        o.lock_open  = lock_open;
        o.locked_out = locked_out;
        o.fail_cnt   = fail_cnt;
        o.busy       = busy;
`ifdef UART_LOCK_SEQ_ACK_TX_EN
        o.tx_start   = tx_start;
        o.tx_byte    = tx_byte;
`else
        o.tx_start   = 1'b0;
        o.tx_byte    = 8'h00;
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_mode     = M_IDLE;
        m_fails    = 0;
        m_digits.delete();
        m_pend     = 0;
        m_tx_start = 0;
        m_tx_byte  = 0;
    endtask

    // Wrong attempt: count it (saturating) and decide between lockout and idle.
    task automatic model_wrong(output int ev);
        m_fails = (m_fails + 1 > int'(MAXF)) ? int'(MAXF) : m_fails + 1;
        if (m_fails == int'(MAXF)) begin
            m_mode     = M_LOCK;
            m_deadline = cyc + int'(LOCK_N);
            ev         = 8'h4C;
        end else begin
            m_mode = M_IDLE;
            ev     = 8'h4E;
        end
    endtask

    // Advance the model by one clock edge and queue the outputs expected after it.
    task automatic model_step(input bit v, input logic [7:0] b, input bit txb);
        int   ev;
        int   val;
        obs_t e;
        ev = 0;
        cyc++;
        case (m_mode)
            M_IDLE: begin
                if (v && b == 8'h41) begin
                    m_mode = M_COLLECT;
                    m_digits.delete();
                    m_deadline = cyc + int'(BT_N);
                end
            end
            M_COLLECT: begin
                if (v) begin
                    if (b >= 8'h30 && b <= 8'h39) begin
                        m_digits.push_back(int'(b) - 48);
                        m_deadline = cyc + int'(BT_N);
                        if (m_digits.size() == 4) begin
                            val = m_digits[0] * 1000 + m_digits[1] * 100 +
                                  m_digits[2] * 10 + m_digits[3];
                            if (val == pin_dec) begin
                                m_mode     = M_OPEN;
                                m_fails    = 0;
                                m_deadline = cyc + int'(OPEN_N);
                                ev         = 8'h4B;
                            end else begin
                                model_wrong(ev);
                            end
                        end
                    end else if (b == 8'h43) begin
                        m_mode = M_IDLE;
                    end else if (b == 8'h41) begin
                        m_digits.delete();
                        m_deadline = cyc + int'(BT_N);
                    end else begin
                        model_wrong(ev);
                    end
                end else if (cyc == m_deadline) begin
                    m_mode = M_IDLE;
                end
            end
            M_OPEN: begin
                if ((v && b == 8'h43) || cyc == m_deadline) begin
                    m_mode = M_IDLE;
                    ev     = 8'h58;
                end
            end
            default: begin
                if (cyc == m_deadline) begin
                    m_mode  = M_IDLE;
                    m_fails = 0;
                end
            end
        endcase

        m_tx_start = 0;
        if (m_pend && !txb) begin
            m_tx_start = 1;
            m_tx_byte  = m_pend_byte;
            m_pend     = 0;
        end
        if (ev != 0) begin
            m_pend      = 1;
            m_pend_byte = ev;
        end

        e.lock_open  = (m_mode == M_OPEN);
        e.locked_out = (m_mode == M_LOCK);
        e.fail_cnt   = 4'(m_fails);
        e.busy       = (m_mode == M_COLLECT);
`ifdef UART_LOCK_SEQ_ACK_TX_EN
        e.tx_start   = m_tx_start;
        e.tx_byte    = 8'(m_tx_byte);
`else
        e.tx_start   = 1'b0;
        e.tx_byte    = 8'h00;
`endif
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
    endtask

    // Monitor: compare DUT outputs against the queued expectation after each edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            int   c;
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            a = sample_obs();
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs cycle %0d: got open=%b lockout=%b fails=%0d busy=%b txs=%b txb=%h, want open=%b lockout=%b fails=%0d busy=%b txs=%b txb=%h",
                         c, a.lock_open, a.locked_out, a.fail_cnt, a.busy, a.tx_start,
                         a.tx_byte, e.lock_open, e.locked_out, e.fail_cnt, e.busy,
                         e.tx_start, e.tx_byte);
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] b);
        cmd_valid = v;
        cmd_byte  = b;
        @(posedge clk);
        model_step(v, b, tx_busy);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            drive(1'b1, s[i]);
            idle(gap);
        end
    endtask

    task automatic check_zero(input string name);
        obs_t a;
        a = sample_obs();
        n_cmp++;
        if (a !== '0) begin
            n_fail++;
            $display("FAIL %s: got open=%b lockout=%b fails=%0d busy=%b txs=%b txb=%h, want all zero",
                     name, a.lock_open, a.locked_out, a.fail_cnt, a.busy, a.tx_start, a.tx_byte);
        end
    endtask

    // Reset pulse away from the clock edge; outputs must clear without waiting for a clock.
    task automatic async_reset(input string name);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero(name);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        tx_busy   = 1'b0;
        #1;
        check_zero("power_on_reset");
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Correct PIN, then auto-relock after the open time.
        idle(3);
        send_str("A1234", 0);
        idle(OPEN_N + 10);

        // Manual close after 10 cycles, then close on the exact expiry cycle.
        send_str("A1234", 0);
        idle(10);
        send_str("C", 0);
        idle(3);
        send_str("A1234", 0);
        idle(OPEN_N - 1);
        send_str("C", 0);
        idle(5);

        // Three wrong PINs -> lockout; correct PIN ignored; then opens after lockout.
        send_str("A9999", 1);
        send_str("A9999", 0);
        send_str("A9999", 2);
        send_str("A1234", 0);
        idle(LOCK_N + 5);
        send_str("A1234", 0);
        send_str("C", 0);
        idle(2);

        // Byte timeout, bad byte, restart mid-PIN.
        send_str("A12", 0);
        idle(BT_N + 5);
        send_str("A1x", 0);
        idle(3);
        send_str("A1A1234", 0);
        idle(4);
        send_str("C", 0);

        // Asynchronous reset mid-COLLECT and mid-OPEN.
        send_str("A12", 0);
        async_reset("reset_mid_collect");
        send_str("A1234", 0);
        idle(5);
        async_reset("reset_mid_open");
        idle(2);

`ifdef UART_LOCK_SEQ_ACK_TX_EN
        // Transmitter busy across N, N, L: only the newest event is sent once it frees.
        tx_busy = 1'b1;
        send_str("A9999", 0);
        send_str("A9999", 0);
        send_str("A9999", 0);
        idle(5);
        tx_busy = 1'b0;
        idle(LOCK_N + 5);
        send_str("A1234", 0);
        idle(3);
        send_str("C", 0);
        idle(3);
`endif

        // Random traffic.
        for (int it = 0; it < 300; it++) begin
            int k;
            k = $urandom_range(0, 9);
`ifdef UART_LOCK_SEQ_ACK_TX_EN
            tx_busy = ($urandom_range(0, 3) == 0);
`endif
            case (k)
                0, 1, 2: send_str("A1234", $urandom_range(0, 3));
                3, 4: begin
                    drive(1'b1, 8'h41);
                    for (int j = 0; j < 4; j++) begin
                        drive(1'b1, 8'h30 + 8'($urandom_range(0, 9)));
                        idle($urandom_range(0, 2));
                    end
                end
                5: drive(1'b1, 8'h43);
                6: drive(1'b1, 8'($urandom));
                7: idle($urandom_range(0, 120));
                8: begin
                    send_str("A1", 0);
                    idle($urandom_range(45, 55));
                end
                default: begin
                    drive(1'b1, 8'h41);
                    drive(1'b1, 8'h35);
                    drive(1'b1, 8'h41);
                end
            endcase
        end
        tx_busy = 1'b0;
        idle(2);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
